alu_cmd_sequencer: RTL and testbench

- Sequential front end that drives the combinational BreadBoard ALU, which has 16-bit operands, a 4-bit op_code, a 32-bit result and a 2-bit err_code.
- Accepts a stream of {opcode, operand} commands over a valid/ready handshake.
- Feeds the ALU with input1 = accumulator and input2 = operand, waits a fixed settle time, then captures the ALU result into a 32-bit accumulator.
- Returns each result downstream over a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_seq_settle_ctr.sv | 28 ++
 rtl/alu_cmd_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, result codes and FSM state type for the ALU command sequencer.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_MOD   = 4'd4;
  localparam logic [3:0] OP_LOAD  = 4'd14;
  localparam logic [3:0] OP_CLEAR = 4'd15;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_SAT   = 2'd1;
  localparam logic [1:0] ERR_ALU   = 2'd2;
  localparam logic [1:0] ERR_UNSUP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESULT
  } seq_state_t;

endpackage

// File: rtl/alu_seq_settle_ctr.sv
// Loadable down-counter that times how long the ALU inputs are held before capture.
module alu_seq_settle_ctr #(
  parameter int CTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CTR_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CTR_W-1:0] r_count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accumulator-based command front end for the combinational BreadBoard ALU.
// Define ALU_SEQ_SAT_EN to clamp captured results to the signed DATA_W range.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int RES_W         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_operand,
  output logic [DATA_W-1:0] alu_input1,
  output logic [DATA_W-1:0] alu_input2,
  output logic [3:0]        alu_op_code,
  input  logic [RES_W-1:0]  alu_output1,
  input  logic [1:0]        alu_err_code,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [1:0]        res_err,
  output logic              busy
);

  localparam int CTR_W = 4;

`ifdef ALU_SEQ_SAT_EN
  localparam logic signed [RES_W-1:0] SAT_MAX = RES_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [RES_W-1:0] SAT_MIN = -SAT_MAX - 1;
`endif

  seq_state_t        r_state, w_state_nxt;
  logic [RES_W-1:0]  r_acc, w_acc_nxt;
  logic [DATA_W-1:0] r_in1, w_in1_nxt;
  logic [DATA_W-1:0] r_in2, w_in2_nxt;
  logic [3:0]        r_op, w_op_nxt;
  logic [1:0]        r_err, w_err_nxt;
  logic              w_ctr_load;
  logic              w_ctr_zero;

  alu_seq_settle_ctr #(.CTR_W(CTR_W)) u_settle_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_ctr_load),
    .i_load_val (CTR_W'(SETTLE_CYCLES - 1)),
    .i_dec      (r_state == ST_SETTLE),
    .o_zero     (w_ctr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_op    <= '0;
      r_err   <= ERR_OK;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_in1   <= w_in1_nxt;
      r_in2   <= w_in2_nxt;
      r_op    <= w_op_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_in1_nxt   = r_in1;
    w_in2_nxt   = r_in2;
    w_op_nxt    = r_op;
    w_err_nxt   = r_err;
    w_ctr_load  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_state_nxt = ST_RESULT;
          case (cmd_op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: begin
              w_in1_nxt   = r_acc[DATA_W-1:0];
              w_in2_nxt   = cmd_operand;
              w_op_nxt    = cmd_op;
              w_ctr_load  = 1'b1;
              w_state_nxt = ST_SETTLE;
            end
            OP_LOAD: begin
              w_acc_nxt = {{(RES_W-DATA_W){cmd_operand[DATA_W-1]}}, cmd_operand};
              w_err_nxt = ERR_OK;
            end
            OP_CLEAR: begin
              w_acc_nxt = '0;
              w_err_nxt = ERR_OK;
            end
            default: w_err_nxt = ERR_UNSUP;
          endcase
        end
      end
      ST_SETTLE: begin
        if (w_ctr_zero) begin
          w_state_nxt = ST_RESULT;
          // Bit 1 flags divide/mod by zero; bit 0 alone is not an error here.
          if (alu_err_code >= 2'b10) begin
            w_err_nxt = ERR_ALU;
          end else begin
            w_acc_nxt = alu_output1;
            w_err_nxt = ERR_OK;
`ifdef ALU_SEQ_SAT_EN
            if ($signed(alu_output1) > SAT_MAX) begin
              w_acc_nxt = SAT_MAX;
              w_err_nxt = ERR_SAT;
            end else if ($signed(alu_output1) < SAT_MIN) begin
              w_acc_nxt = SAT_MIN;
              w_err_nxt = ERR_SAT;
            end
`endif
          end
        end
      end
      ST_RESULT: begin
        if (res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Held low while reset is asserted so commands presented during reset are ignored.
  assign cmd_ready   = rst_n && (r_state == ST_IDLE);
  assign res_valid   = (r_state == ST_RESULT);
  assign busy        = (r_state != ST_IDLE);
  assign res_data    = r_acc;
  assign res_err     = r_err;
  assign alu_input1  = r_in1;
  assign alu_input2  = r_in2;
  assign alu_op_code = r_op;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural ALU model.
module tb_alu_cmd_sequencer;

  localparam int DATA_W        = 16;
  localparam int RES_W         = 32;
  localparam int SETTLE_CYCLES = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_op = '0;
  logic [DATA_W-1:0] cmd_operand = '0;
  logic [DATA_W-1:0] alu_input1, alu_input2;
  logic [3:0]        alu_op_code;
  logic [RES_W-1:0]  alu_output1;
  logic [1:0]        alu_err_code;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [RES_W-1:0]  res_data;
  logic [1:0]        res_err;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] last_in1;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DATA_W(DATA_W), .RES_W(RES_W), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_op_code(alu_op_code),
    .alu_output1(alu_output1), .alu_err_code(alu_err_code),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy)
  );

  // Behavioural BreadBoard ALU: signed 16-bit operands, signed 32-bit result.
  logic signed [31:0] m_a, m_b;
  always_comb begin
    m_a          = 32'(signed'(alu_input1));
    m_b          = 32'(signed'(alu_input2));
    alu_output1  = '0;
    alu_err_code = 2'b00;
    case (alu_op_code)
      4'd0: alu_output1 = m_a + m_b;
      4'd1: alu_output1 = m_a - m_b;
      4'd2: alu_output1 = m_a * m_b;
      4'd3: if (m_b == 0) alu_err_code = 2'b10; else alu_output1 = m_a / m_b;
      4'd4: if (m_b == 0) alu_err_code = 2'b10; else alu_output1 = m_a % m_b;
      default: alu_err_code = 2'b01;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one command, wait for its result, check it and latency, then accept it.
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [15:0] operand,
                         input logic [31:0] exp_data, input logic [1:0] exp_err,
                         input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = operand;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    last_in1  = alu_input1;
    lat = 1;
    while (!res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, res_data, exp_data);
    check({tag, "_err"}, 32'(res_err), 32'(exp_err));
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_done"}, {30'd0, res_valid, cmd_ready}, 32'b01);
  endtask

  initial begin
    #12;
    check("rst_outputs", {28'd0, cmd_ready, res_valid, busy, 1'b0}, 32'd0);
    check("rst_data", res_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", {res_err, alu_op_code, alu_input1}, 32'd0);
    check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    run_cmd("load11", 4'd14, 16'd11, 32'd11, 2'b00, 1);
    run_cmd("add15",  4'd0,  16'd15, 32'd26, 2'b00, SETTLE_CYCLES + 1);
    run_cmd("sub30",  4'd1,  16'd30, 32'hFFFF_FFFC, 2'b00, SETTLE_CYCLES + 1);
    check("sub30_in1", 32'(last_in1), 32'd26);

    run_cmd("load32000", 4'd14, 16'd32000, 32'd32000, 2'b00, 1);
`ifdef ALU_SEQ_SAT_EN
    run_cmd("mul16000", 4'd2, 16'd16000, 32'd32767, 2'b01, SETTLE_CYCLES + 1);
    run_cmd("add0", 4'd0, 16'd0, 32'd32767, 2'b00, SETTLE_CYCLES + 1);
    check("add0_in1", 32'(last_in1), 32'h7FFF);
`else
    run_cmd("mul16000", 4'd2, 16'd16000, 32'd512000000, 2'b00, SETTLE_CYCLES + 1);
    run_cmd("add0", 4'd0, 16'd0, 32'hFFFF_8000, 2'b00, SETTLE_CYCLES + 1);
    check("add0_in1", 32'(last_in1), 32'h8000);
`endif

    run_cmd("reload11", 4'd14, 16'd11, 32'd11, 2'b00, 1);
    run_cmd("div0",     4'd3,  16'd0,  32'd11, 2'b10, SETTLE_CYCLES + 1);
    run_cmd("div3",     4'd3,  16'd3,  32'd3,  2'b00, SETTLE_CYCLES + 1);
    run_cmd("unsup7",   4'd7,  16'd99, 32'd3,  2'b11, 1);
    run_cmd("clear",    4'd15, 16'd55, 32'd0,  2'b00, 1);
    run_cmd("loadneg",  4'd14, 16'hFFF6, 32'hFFFF_FFF6, 2'b00, 1);

    // Backpressure: result must hold while res_ready stays low.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_operand = 16'd20;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (SETTLE_CYCLES) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {res_data[27:0], res_err, res_valid, cmd_ready}, {28'd10, 2'b00, 1'b1, 1'b0});
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp_release", {30'd0, res_valid, cmd_ready}, 32'b01);

    // Reset during SETTLE discards the in-flight command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd2; cmd_operand = 16'd7;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mid_settle_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {res_err, alu_op_code, alu_input1, 7'd0, res_valid, busy, cmd_ready},
          32'd0);
    check("mid_rst_data", res_data, 32'd0);
    check("mid_rst_in2", 32'(alu_input2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", {30'd0, res_valid, cmd_ready}, 32'b01);
    end
    run_cmd("load5", 4'd14, 16'd5, 32'd5, 2'b00, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
